// File: rtl/fpu_param.sv
// fpu_param: multi-cycle parametrised floating-point add/sub/mul with RNE rounding and flush-to-zero.
// Define FPU_MUL_EN to build the iterative multiplier; without it op=10 behaves as reserved.
module fpu_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic [EXP_W+MAN_W:0] R,
  output logic [3:0]           flags,
  output logic                 busy,
  output logic                 done
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int M      = MAN_W + 1;
  localparam int XW     = 2 * M + 2;
  localparam int LZW    = $clog2(XW) + 1;
  localparam int EW     = ((EXP_W > LZW) ? EXP_W : LZW) + 3;
  localparam int EMAX_I = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_EXEC, S_NORM, S_ROUND} state_t;
  state_t r_state;

  logic [W-1:0]          r_a, r_b, r_spec_r;
  logic [1:0]            r_op;
  logic                  r_sa, r_sb, r_sign, r_spec;
  logic [EXP_W-1:0]      r_ea, r_eb;
  logic [M-1:0]          r_ma, r_mb;
  logic [3:0]            r_spec_f;
  logic signed [EW-1:0]  r_exp;
  logic [XW-1:0]         r_mant;
`ifdef FPU_MUL_EN
  localparam int CW     = $clog2(M + 1);
  localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
  logic [XW-1:0]         r_mcand;
  logic [M-1:0]          r_mplier;
  logic [CW-1:0]         r_cnt;
`endif

  // Operand classification (subnormals count as zero)
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_sa, w_sb, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic             w_a_snan, w_b_snan, w_is_mul, w_resv, w_spec;
  logic [M-1:0]     w_ma, w_mb;
  logic [W-1:0]     w_spec_r;
  logic [3:0]       w_spec_f;

  assign w_sa     = r_a[W-1];
  assign w_sb     = r_b[W-1] ^ (r_op == 2'b01);
  assign w_ea     = r_a[W-2:MAN_W];
  assign w_eb     = r_b[W-2:MAN_W];
  assign w_fa     = r_a[MAN_W-1:0];
  assign w_fb     = r_b[MAN_W-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == EMAX) && (w_fa == '0);
  assign w_b_inf  = (w_eb == EMAX) && (w_fb == '0);
  assign w_a_nan  = (w_ea == EMAX) && (w_fa != '0);
  assign w_b_nan  = (w_eb == EMAX) && (w_fb != '0);
  assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
  assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];
  assign w_ma     = w_a_zero ? '0 : {1'b1, w_fa};
  assign w_mb     = w_b_zero ? '0 : {1'b1, w_fb};
`ifdef FPU_MUL_EN
  assign w_is_mul = (r_op == 2'b10);
  assign w_resv   = (r_op == 2'b11);
`else
  assign w_is_mul = 1'b0;
  assign w_resv   = r_op[1];
`endif

  always_comb begin
    w_spec   = 1'b1;
    w_spec_r = QNAN;
    w_spec_f = 4'b1000;
    if (w_resv) begin
      w_spec_f = 4'b1000;
    end else if (w_a_nan || w_b_nan) begin
      w_spec_f = {w_a_snan | w_b_snan, 3'b000};
    end else if (w_is_mul) begin
      if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) w_spec_f = 4'b1000;
      else if (w_a_inf || w_b_inf) begin
        w_spec_r = {w_sa ^ w_sb, EMAX, {MAN_W{1'b0}}};
        w_spec_f = '0;
      end else w_spec = 1'b0;
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
      w_spec_f = 4'b1000;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_r = {w_a_inf ? w_sa : w_sb, EMAX, {MAN_W{1'b0}}};
      w_spec_f = '0;
    end else w_spec = 1'b0;
  end

  // Add/sub: the smaller operand is shifted right; every bit lost off the bottom folds into bit 0
  logic             w_a_big, w_big_s, w_lost;
  logic [EXP_W-1:0] w_big_e, w_small_e, w_d;
  logic [M-1:0]     w_big_m, w_small_m;
  logic [XW-1:0]    w_big_x, w_small_x, w_shift, w_align, w_sum;

  assign w_a_big   = {r_ea, r_ma} >= {r_eb, r_mb};
  assign w_big_e   = w_a_big ? r_ea : r_eb;
  assign w_small_e = w_a_big ? r_eb : r_ea;
  assign w_big_m   = w_a_big ? r_ma : r_mb;
  assign w_small_m = w_a_big ? r_mb : r_ma;
  assign w_big_s   = w_a_big ? r_sa : r_sb;
  assign w_d       = w_big_e - w_small_e;
  assign w_big_x   = {1'b0, w_big_m, {(M+1){1'b0}}};
  assign w_small_x = {1'b0, w_small_m, {(M+1){1'b0}}};
  assign w_shift   = w_small_x >> w_d;
  assign w_lost    = (w_shift << w_d) != w_small_x;
  assign w_align   = w_shift | XW'(w_lost);
  assign w_sum     = (r_sa != r_sb) ? (w_big_x - w_align) : (w_big_x + w_align);

  logic [LZW-1:0] w_lz;
  always_comb begin
    w_lz = '0;
    for (int unsigned i = 0; i < XW; i++)
      if (r_mant[i]) w_lz = LZW'(XW - 1 - i);
  end

  // Rounding: leading one sits at the top bit after NORM
  logic                 w_g, w_st, w_up;
  logic [M-1:0]         w_kept;
  logic [M:0]           w_rnd;
  logic signed [EW-1:0] w_exp_f;
  logic [W-1:0]         w_res;
  logic [3:0]           w_fl;

  assign w_kept  = r_mant[XW-1 -: M];
  assign w_g     = r_mant[XW-1-M];
  assign w_st    = |r_mant[XW-2-M:0];
  assign w_up    = w_g & (w_st | w_kept[0]);
  assign w_rnd   = {1'b0, w_kept} + {{M{1'b0}}, w_up};
  assign w_exp_f = r_exp + EW'(w_rnd[M]);

  always_comb begin
    w_res = {r_sign, {(W-1){1'b0}}};
    w_fl  = '0;
    if (r_spec) begin
      w_res = r_spec_r;
      w_fl  = r_spec_f;
    end else if (w_rnd[M] | w_rnd[MAN_W]) begin
      if (int'(w_exp_f) >= EMAX_I) begin
        w_res = {r_sign, EMAX, {MAN_W{1'b0}}};
        w_fl  = 4'b0101;
      end else if (int'(w_exp_f) <= 0) begin
        w_fl  = 4'b0011;
      end else begin
        w_res = {r_sign, w_exp_f[EXP_W-1:0], w_rnd[M] ? {MAN_W{1'b0}} : w_rnd[MAN_W-1:0]};
        w_fl  = {3'b000, w_g | w_st};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      R        <= '0;
      flags    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_sign   <= 1'b0;
      r_spec   <= 1'b0;
      r_spec_r <= '0;
      r_spec_f <= '0;
      r_ea     <= '0;
      r_eb     <= '0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_exp    <= '0;
      r_mant   <= '0;
`ifdef FPU_MUL_EN
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_a     <= A;
          r_b     <= B;
          r_op    <= op;
          busy    <= 1'b1;
          r_state <= S_UNPACK;
        end
        S_UNPACK: begin
          r_sa     <= w_sa;
          r_sb     <= w_sb;
          r_ea     <= w_ea;
          r_eb     <= w_eb;
          r_ma     <= w_ma;
          r_mb     <= w_mb;
          r_spec   <= w_spec;
          r_spec_r <= w_spec_r;
          r_spec_f <= w_spec_f;
`ifdef FPU_MUL_EN
          r_mant   <= '0;
          r_mcand  <= XW'(w_ma);
          r_mplier <= w_mb;
          r_cnt    <= '0;
`endif
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          if (r_spec) r_state <= S_NORM;
`ifdef FPU_MUL_EN
          // One shift-add per cycle; the extra final cycle aligns the product and sets the exponent
          else if (r_op == 2'b10) begin
            if (r_cnt != CW'(M)) begin
              if (r_mplier[0]) r_mant <= r_mant + r_mcand;
              r_mcand  <= r_mcand << 1;
              r_mplier <= r_mplier >> 1;
              r_cnt    <= r_cnt + 1'b1;
            end else begin
              r_mant  <= r_mant << 2;
              r_exp   <= EW'(r_ea) + EW'(r_eb) - EW'(BIAS_I - 1);
              r_sign  <= r_sa ^ r_sb;
              r_state <= S_NORM;
            end
          end
`endif
          else begin
            r_mant  <= w_sum;
            r_exp   <= EW'(w_big_e) + EW'(1);
            r_sign  <= (w_sum == '0) ? (r_sa & r_sb) : w_big_s;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_mant  <= r_mant << w_lz;
          r_exp   <= r_exp - EW'(w_lz);
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          R       <= w_res;
          flags   <= w_fl;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_param.sv
// Directed self-checking bench for fpu_param: binary32 and binary16 instances, FPU_MUL_EN aware.
module tb_fpu_param;
`ifdef FPU_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start32 = 1'b0, start16 = 1'b0;
  logic [1:0]  op32 = '0, op16 = '0;
  logic [31:0] a32 = '0, b32 = '0, r32;
  logic [15:0] a16 = '0, b16 = '0, r16;
  logic [3:0]  fl32, fl16;
  logic        busy32, busy16, done32, done16;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpu_param #(.EXP_W(8), .MAN_W(23)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .A(a32), .B(b32),
    .R(r32), .flags(fl32), .busy(busy32), .done(done32));

  fpu_param #(.EXP_W(5), .MAN_W(10)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .A(a16), .B(b16),
    .R(r16), .flags(fl16), .busy(busy16), .done(done16));

  // Stimulus only: issues one operation and reports what came back (lat = -1 on timeout)
  task automatic run_op(input bit sel, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] fl, output int lat,
                        output bit busy_ok, output bit pulse_ok);
    bit busy_at_done;
    @(posedge clk); #1;
    if (sel) begin op16 = o; a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1; end
    else     begin op32 = o; a32 = a;       b32 = b;       start32 = 1'b1; end
    @(posedge clk); #1;
    start32 = 1'b0; start16 = 1'b0;
    a32 = ~a32; b32 = ~b32; a16 = ~a16; b16 = ~b16; op32 = 2'b11; op16 = 2'b11;
    busy_ok = sel ? busy16 : busy32;
    lat = -1;
    busy_at_done = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (sel ? done16 : done32) begin
        lat = i;
        busy_at_done = sel ? busy16 : busy32;
        break;
      end
    end
    r  = sel ? {16'h0000, r16} : r32;
    fl = sel ? fl16 : fl32;
    @(posedge clk); #1;
    pulse_ok = !busy_at_done && !(sel ? done16 : done32);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({r32, fl32, busy32, done32} !== 38'h0) begin
      n_bad++; $display("FAIL reset32 got R=%h fl=%h busy=%b done=%b want all 0", r32, fl32, busy32, done32);
    end
    n_cmp++;
    if ({r16, fl16, busy16, done16} !== 22'h0) begin
      n_bad++; $display("FAIL reset16 got R=%h fl=%h busy=%b done=%b want all 0", r16, fl16, busy16, done16);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_add32();
    logic [31:0] r; logic [3:0] f; int lat; bit bo, po;
    run_op(1'b0, 2'b00, 32'h3F800000, 32'h40000000, r, f, lat, bo, po);
    n_cmp++; if (r !== 32'h40400000) begin n_bad++; $display("FAIL add32_R got=%h want=40400000", r); end
    n_cmp++; if (f !== 4'h0) begin n_bad++; $display("FAIL add32_flags got=%h want=0", f); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL add32_latency got=%0d want=4", lat); end
    n_cmp++; if (bo !== 1'b1) begin n_bad++; $display("FAIL add32_busy_rise got=%b want=1", bo); end
    n_cmp++; if (po !== 1'b1) begin n_bad++; $display("FAIL add32_done_pulse got=%b want=1", po); end
  endtask

  task automatic test_mul32();
    logic [31:0] r; logic [3:0] f; int lat; bit bo, po;
    run_op(1'b0, 2'b10, 32'h3FC00000, 32'h40200000, r, f, lat, bo, po);
    n_cmp++; if (r !== (MUL ? 32'h40700000 : 32'h7FC00000)) begin
      n_bad++; $display("FAIL mul32_R got=%h want=%h", r, MUL ? 32'h40700000 : 32'h7FC00000); end
    n_cmp++; if (f !== (MUL ? 4'h0 : 4'h8)) begin
      n_bad++; $display("FAIL mul32_flags got=%h want=%h", f, MUL ? 4'h0 : 4'h8); end
    n_cmp++; if (lat !== (MUL ? 28 : 4)) begin
      n_bad++; $display("FAIL mul32_latency got=%0d want=%0d", lat, MUL ? 28 : 4); end
    n_cmp++; if (po !== 1'b1) begin n_bad++; $display("FAIL mul32_done_pulse got=%b want=1", po); end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, r;
    logic [3:0]  f;
  } vec_t;

  task automatic test_specials();
    vec_t v[13];
    logic [31:0] r; logic [3:0] f; int lat; bit bo, po;
    v[0]  = '{2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'h8};
    v[1]  = '{2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'h5};
    v[2]  = '{2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'h1};
    v[3]  = '{2'b00, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'h1};
    v[4]  = '{2'b00, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0};
    v[5]  = '{2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8};
    v[6]  = '{2'b11, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 4'h8};
    v[7]  = '{2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'h0};
    v[8]  = '{2'b01, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'h0};
    v[9]  = '{2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'h0};
    v[10] = '{2'b00, 32'hBF800000, 32'hBF800000, 32'hC0000000, 4'h0};
    v[11] = '{2'b01, 32'h00800000, 32'h00800001, 32'h80000000, 4'h3};
    v[12] = '{2'b10, 32'h7F7FFFFF, 32'h40000000, MUL ? 32'h7F800000 : 32'h7FC00000, MUL ? 4'h5 : 4'h8};
    for (int i = 0; i < 13; i++) begin
      run_op(1'b0, v[i].op, v[i].a, v[i].b, r, f, lat, bo, po);
      n_cmp++;
      if (r !== v[i].r || f !== v[i].f) begin
        n_bad++; $display("FAIL special_%0d got R=%h fl=%h want R=%h fl=%h", i, r, f, v[i].r, v[i].f);
      end
      if (i == 0) begin
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL special_latency got=%0d want=4", lat); end
      end
    end
    run_op(1'b0, 2'b10, 32'h00000000, 32'h7F800000, r, f, lat, bo, po);
    n_cmp++;
    if (r !== 32'h7FC00000 || f !== 4'h8 || lat !== 4) begin
      n_bad++; $display("FAIL zero_times_inf got R=%h fl=%h lat=%0d want R=7fc00000 fl=8 lat=4", r, f, lat);
    end
  endtask

  task automatic test_half();
    logic [31:0] r; logic [3:0] f; int lat; bit bo, po;
    run_op(1'b1, 2'b00, 32'h3C00, 32'h3C00, r, f, lat, bo, po);
    n_cmp++;
    if (r[15:0] !== 16'h4000 || f !== 4'h0 || lat !== 4) begin
      n_bad++; $display("FAIL half_add got R=%h fl=%h lat=%0d want R=4000 fl=0 lat=4", r[15:0], f, lat);
    end
    run_op(1'b1, 2'b10, 32'h3E00, 32'h4100, r, f, lat, bo, po);
    n_cmp++;
    if (r[15:0] !== (MUL ? 16'h4380 : 16'h7E00) || f !== (MUL ? 4'h0 : 4'h8) || lat !== (MUL ? 15 : 4)) begin
      n_bad++; $display("FAIL half_mul got R=%h fl=%h lat=%0d want R=%h fl=%h lat=%0d",
                        r[15:0], f, lat, MUL ? 16'h4380 : 16'h7E00, MUL ? 4'h0 : 4'h8, MUL ? 15 : 4);
    end
  endtask

  task automatic test_ignore_busy();
    int lat = -1;
    int extra = 0;
    @(posedge clk); #1;
    op32 = 2'b00; a32 = 32'h3F800000; b32 = 32'h40000000; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start32 = (i == 2);
      if (i == 2) begin a32 = 32'h40000000; b32 = 32'h40000000; end
      if (done32) begin
        if (lat < 0) lat = i;
        else extra++;
      end
    end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL ignore_latency got=%0d want=4", lat); end
    n_cmp++; if (r32 !== 32'h40400000) begin n_bad++; $display("FAIL ignore_R got=%h want=40400000", r32); end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ignore_extra_done got=%0d want=0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat1 = -1;
    int lat2 = -1;
    @(posedge clk); #1;
    op32 = 2'b00; a32 = 32'h3F800000; b32 = 32'h40000000; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done32) begin lat1 = i; break; end
    end
    n_cmp++; if (r32 !== 32'h40400000) begin n_bad++; $display("FAIL b2b_first_R got=%h want=40400000", r32); end
    op32 = 2'b00; a32 = 32'h40000000; b32 = 32'h40000000; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    n_cmp++; if (busy32 !== 1'b1) begin n_bad++; $display("FAIL b2b_accept busy=%b want=1", busy32); end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done32) begin lat2 = i; break; end
    end
    n_cmp++;
    if (lat1 !== 4 || lat2 !== 4 || r32 !== 32'h40800000) begin
      n_bad++; $display("FAIL b2b_second got lat1=%0d lat2=%0d R=%h want 4 4 40800000", lat1, lat2, r32);
    end
  endtask

  task automatic test_abort();
    localparam int RSTC = MUL ? 10 : 3;
    localparam int ST2C = MUL ? 3 : 2;
    bit saw_done = 1'b0;
    bit busy_pre = 1'b0;
    logic [31:0] r; logic [3:0] f; int lat; bit bo, po;
    @(posedge clk); #1;
    op32 = 2'b10; a32 = 32'h3FC00000; b32 = 32'h40200000; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    for (int c = 1; c <= RSTC; c++) begin
      @(posedge clk); #1;
      if (done32) saw_done = 1'b1;
      start32 = (c == ST2C);
      if (c == ST2C) begin op32 = 2'b00; a32 = 32'h40000000; b32 = 32'h40000000; end
    end
    busy_pre = busy32;
    rst = 1'b0;
    #1;
    n_cmp++; if (busy_pre !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before got=%b want=1", busy_pre); end
    n_cmp++;
    if ({r32, fl32, busy32, done32} !== 38'h0) begin
      n_bad++; $display("FAIL abort_outputs got R=%h fl=%h busy=%b done=%b want all 0", r32, fl32, busy32, done32);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done32) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done got=%b want=0", saw_done); end
    run_op(1'b0, 2'b00, 32'h3F800000, 32'h40000000, r, f, lat, bo, po);
    n_cmp++;
    if (r !== 32'h40400000 || f !== 4'h0 || lat !== 4) begin
      n_bad++; $display("FAIL abort_recover got R=%h fl=%h lat=%0d want R=40400000 fl=0 lat=4", r, f, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add32();
    test_mul32();
    test_specials();
    test_half();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before completion (compared=%0d)", n_cmp);
    $fatal(1);
  end
endmodule
